fpu_share_arbiter: RTL and testbench
====================================

# fpu_share_arbiter

Round-robin arbiter sharing one `fpnew_wrapper` instance among `NB_CORES` APU masters in a cluster.

- **Request side:**
  - Picks one eligible core request per cycle.
  - Tags the request with the core index on the FPU `ID` field.
  - Forwards the request to the FPU.
- **Response side:**
  - Routes each FPU response back to its originating core using the returned ID.
  - Registers the response for one cycle.
- **Limits and errors:**
  - Caps the number of in-flight operations per core.
  - Flags responses that cannot be routed.

## Interface

Parameters:

- `NB_CORES`, 4: number of APU masters (≥2).
- `NB_ARGS`, 2: operands per request.
- `DATA_WIDTH`, 32: operand/result width.
- `OPCODE_WIDTH`, 6: APU opcode width.
- `FLAGS_IN_WIDTH`, 15: request flags width.
- `FLAGS_OUT_WIDTH`, 5: response status width.
- `ID_WIDTH`, 9: FPU tag width; must be ≥ `CORE_BITS`.
- `MAX_OUTSTANDING`, 2: maximum in-flight operations per core (≥1).
- `CORE_BITS`, derived as `$clog2(NB_CORES)`: core index width.
- `CNT_BITS`, derived as `$clog2(MAX_OUTSTANDING+1)`: in-flight counter width.

Ports (clock and reset first; reset `rst_n` is asynchronous, active-low; clock is `clk`):

- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `core_req_i`  in  NB_CORES  per-core request valid
- `core_gnt_o`  out  NB_CORES  per-core grant
- `core_operands_i`  in  NB_CORES×NB_ARGS×DATA_WIDTH  per-core operands
- `core_op_i`  in  NB_CORES×OPCODE_WIDTH  per-core opcode
- `core_flags_i`  in  NB_CORES×FLAGS_IN_WIDTH  per-core flags
- `core_rvalid_o`  out  NB_CORES  per-core response valid
- `core_rdata_o`  out  DATA_WIDTH  response data, shared by all cores
- `core_rflags_o`  out  FLAGS_OUT_WIDTH  response status, shared by all cores
- `fpu_req_o`  out  1  request to FPU
- `fpu_gnt_i`  in  1  FPU accept
- `fpu_ID_o`  out  ID_WIDTH  tag; the core index is zero-extended into it
- `fpu_operands_o`  out  NB_ARGS×DATA_WIDTH  muxed operands
- `fpu_op_o`  out  OPCODE_WIDTH  muxed opcode
- `fpu_flags_o`  out  FLAGS_IN_WIDTH  muxed flags
- `fpu_rvalid_i`  in  1  FPU response valid; not backpressurable
- `fpu_rdata_i`  in  DATA_WIDTH  FPU result
- `fpu_rflags_i`  in  FLAGS_OUT_WIDTH  FPU status
- `fpu_rID_i`  in  ID_WIDTH  returned tag
- `err_o`  out  1  sticky routing-error flag

## Operation

- **Eligibility:** `elig[k] = core_req_i[k] & (cnt[k] < MAX_OUTSTANDING)`.
- **Winner selection:**
  - The winner is the first eligible core at or after `rr_ptr`, searching upward with wrap.
  - `fpu_req_o = |elig`.
  - The FPU payload buses carry the winner's fields.
  - `fpu_ID_o` carries the winner's index.
  - When no core is eligible, the payload buses are don't-care.
- **Grant:** `core_gnt_o[k] = fpu_req_o & fpu_gnt_i & (winner==k)`. At most one grant bit is high per cycle.
- **Pointer update:** on a handshake (`fpu_req_o & fpu_gnt_i`), `rr_ptr <= winner+1`, wrapping to 0 after `NB_CORES-1`. Otherwise it holds.
- **In-flight counters:**
  - `cnt[k]` increments on a grant to core k.
  - It decrements on an accepted response routed to core k.
  - If both happen in the same cycle, it is unchanged.
- **Response routing:** on `fpu_rvalid_i`, compute `idx = fpu_rID_i[CORE_BITS-1:0]`. A response is **valid** when all of the following hold:
  - the upper ID bits are zero;
  - `idx < NB_CORES`;
  - `cnt[idx] != 0`.
- **Valid response:**
  - Next cycle, `core_rvalid_o` is one-hot at `idx` for exactly one cycle.
  - `core_rdata_o` / `core_rflags_o` carry the registered data.
- **Invalid response:**
  - It is dropped: no `rvalid`, no counter change.
  - `err_o` sets and stays set until reset.
- **Idle hold:** `core_rdata_o` / `core_rflags_o` hold their last values when no response is valid.

## Timing

- **Request path:** combinational, zero added latency from `core_req_i` to `fpu_req_o` and from `fpu_gnt_i` to `core_gnt_o`.
- **Response path:** exactly 1 cycle from `fpu_rvalid_i` to `core_rvalid_o`. Back-to-back responses produce back-to-back `rvalid`.
- **Throughput:** one grant per cycle.
- **Fairness:** under continuous contention each requesting core is granted at least once every `NB_CORES` handshakes.
- **Reset values:** all of the following are 0 after reset:
  - `core_gnt_o`, `fpu_req_o` (with all `core_req_i` low);
  - `core_rvalid_o`, `core_rdata_o`, `core_rflags_o`;
  - `err_o`, `rr_ptr`, all `cnt`.
- **Reset mid-operation:**
  - Counters clear; FPU responses already in flight are not tracked.
  - The integrator must reset the FPU together with this block.
  - A response arriving after reset with `cnt==0` is flagged as an error.
- **Request stability:** a core holds its request and payload stable until granted. Dropping a request before grant is permitted, and the arbiter simply re-evaluates.

## Test plan

- **Single core:** core 2 requests with `fpu_gnt_i=1` → `core_gnt_o=4'b0100` the same cycle, `fpu_ID_o=2`. An FPU response with `rID=2`, `rdata=32'h3F800000` → `core_rvalid_o=4'b0100` one cycle later with that data.
- **Full contention:** all 4 cores request continuously with `fpu_gnt_i=1`, and FPU responses return each grant's ID 1 cycle later. → Grant order is 0,1,2,3,0,1…, one per cycle.
- **Outstanding limit:** with `MAX_OUTSTANDING=2`, core 0 requests 3 times with no responses → the first two are granted and the third is held with `gnt=0`. A response with `rID=0` arrives → the third is granted the next cycle.
- **Simultaneous grant and response:** a grant to core 1 and a response `rID=1` in the same cycle with `cnt[1]=1` → `cnt[1]` stays 1, and `core_rvalid_o[1]` pulses next cycle.
- **Bad ID:** a response with `rID=9'h005` (NB_CORES=4) or with `cnt[idx]=0` → no `rvalid`, `err_o=1`, which persists until `rst_n` is asserted.
- **Reset mid-stream:** assert `rst_n=0` during contention → all outputs are 0 immediately. After release, arbitration restarts at core 0.

Source files
------------

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: round-robin sharing of one FPU among NB_CORES APU masters.
// Requests are tagged with the core index; responses are routed back by tag.
module fpu_share_arbiter #(
   parameter int NB_CORES        = 4,
   parameter int NB_ARGS         = 2,
   parameter int DATA_WIDTH      = 32,
   parameter int OPCODE_WIDTH    = 6,
   parameter int FLAGS_IN_WIDTH  = 15,
   parameter int FLAGS_OUT_WIDTH = 5,
   parameter int ID_WIDTH        = 9,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [NB_CORES-1:0]                     core_req_i,
   output logic [NB_CORES-1:0]                     core_gnt_o,
   input  logic [NB_CORES*NB_ARGS*DATA_WIDTH-1:0]  core_operands_i,
   input  logic [NB_CORES*OPCODE_WIDTH-1:0]        core_op_i,
   input  logic [NB_CORES*FLAGS_IN_WIDTH-1:0]      core_flags_i,
   output logic [NB_CORES-1:0]                     core_rvalid_o,
   output logic [DATA_WIDTH-1:0]                   core_rdata_o,
   output logic [FLAGS_OUT_WIDTH-1:0]              core_rflags_o,
   output logic                                    fpu_req_o,
   input  logic                                    fpu_gnt_i,
   output logic [ID_WIDTH-1:0]                     fpu_ID_o,
   output logic [NB_ARGS*DATA_WIDTH-1:0]           fpu_operands_o,
   output logic [OPCODE_WIDTH-1:0]                 fpu_op_o,
   output logic [FLAGS_IN_WIDTH-1:0]               fpu_flags_o,
   input  logic                                    fpu_rvalid_i,
   input  logic [DATA_WIDTH-1:0]                   fpu_rdata_i,
   input  logic [FLAGS_OUT_WIDTH-1:0]              fpu_rflags_i,
   input  logic [ID_WIDTH-1:0]                     fpu_rID_i,
   output logic                                    err_o
);

   localparam int CORE_BITS = $clog2(NB_CORES);
   localparam int CNT_BITS  = $clog2(MAX_OUTSTANDING + 1);
   localparam int OPW       = NB_ARGS * DATA_WIDTH;
   localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_OUTSTANDING);

   logic [CORE_BITS-1:0]       rr_q, rr_d;
   logic [CORE_BITS-1:0]       win, win_lo, win_hi;
   logic                       hi_found;
   logic [CORE_BITS-1:0]       rsp_idx;
   logic [NB_CORES-1:0]        elig, gnt, dec;
   logic                       hs, rsp_hit, rsp_ok;
   logic [CNT_BITS-1:0]        cnt_q [NB_CORES];
   logic [CNT_BITS-1:0]        cnt_d [NB_CORES];
   logic [NB_CORES-1:0]        rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
   logic [FLAGS_OUT_WIDTH-1:0] rflags_q, rflags_d;
   logic                       err_q, err_d;

   // Eligibility, then first eligible at/after rr_q, else lowest eligible
   always_comb begin
      elig     = '0;
      win_lo   = '0;
      win_hi   = '0;
      hi_found = 1'b0;
      for (int i = 0; i < NB_CORES; i++) begin
         elig[i] = core_req_i[i] & (cnt_q[i] < CNT_MAX);
      end
      for (int i = NB_CORES - 1; i >= 0; i--) begin
         if (elig[i]) begin
            win_lo = CORE_BITS'(i);
         end
         if (elig[i] && (CORE_BITS'(i) >= rr_q)) begin
            win_hi   = CORE_BITS'(i);
            hi_found = 1'b1;
         end
      end
      win = hi_found ? win_hi : win_lo;
   end

   assign hs = (|elig) & fpu_gnt_i;

   // Grant vector and response acceptance by returned tag
   always_comb begin
      gnt     = '0;
      dec     = '0;
      rsp_hit = 1'b0;
      rsp_idx = fpu_rID_i[CORE_BITS-1:0];
      for (int k = 0; k < NB_CORES; k++) begin
         gnt[k] = hs && (win == CORE_BITS'(k));
         if ((rsp_idx == CORE_BITS'(k)) && (cnt_q[k] != '0)) begin
            rsp_hit = 1'b1;
         end
      end
      rsp_ok = fpu_rvalid_i && ((fpu_rID_i >> CORE_BITS) == '0) && rsp_hit;
      for (int k = 0; k < NB_CORES; k++) begin
         dec[k] = rsp_ok && (rsp_idx == CORE_BITS'(k));
      end
   end

   // Next state: pointer, in-flight counters, response register, error
   always_comb begin
      rr_d = rr_q;
      if (hs) begin
         rr_d = (win == CORE_BITS'(NB_CORES - 1)) ? '0 : win + 1'b1;
      end
      for (int k = 0; k < NB_CORES; k++) begin
         cnt_d[k] = cnt_q[k];
         if (gnt[k] && !dec[k]) begin
            cnt_d[k] = cnt_q[k] + 1'b1;
         end else if (dec[k] && !gnt[k]) begin
            cnt_d[k] = cnt_q[k] - 1'b1;
         end
      end
      rvalid_d = dec;
      rdata_d  = rsp_ok ? fpu_rdata_i : rdata_q;
      rflags_d = rsp_ok ? fpu_rflags_i : rflags_q;
      err_d    = err_q | (fpu_rvalid_i & ~rsp_ok);
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q     <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         rflags_q <= '0;
         err_q    <= 1'b0;
         for (int k = 0; k < NB_CORES; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         rr_q     <= rr_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rflags_q <= rflags_d;
         err_q    <= err_d;
         for (int k = 0; k < NB_CORES; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   assign fpu_req_o      = |elig;
   assign core_gnt_o     = gnt;
   assign fpu_ID_o       = ID_WIDTH'(win);
   assign fpu_operands_o = core_operands_i[int'(win)*OPW +: OPW];
   assign fpu_op_o       = core_op_i[int'(win)*OPCODE_WIDTH +: OPCODE_WIDTH];
   assign fpu_flags_o    = core_flags_i[int'(win)*FLAGS_IN_WIDTH +: FLAGS_IN_WIDTH];
   assign core_rvalid_o  = rvalid_q;
   assign core_rdata_o   = rdata_q;
   assign core_rflags_o  = rflags_q;
   assign err_o          = err_q;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb_fpu_share_arbiter: directed and random checks of fpu_share_arbiter
// against a queue/array reference model of the arbitration rules.
module tb_fpu_share_arbiter;

   localparam int NC = 4;
   localparam int NA = 2;
   localparam int DW = 32;
   localparam int OW = 6;
   localparam int FI = 15;
   localparam int FO = 5;
   localparam int IW = 9;
   localparam int MO = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic [NC-1:0]       core_req_i, core_gnt_o, core_rvalid_o;
   logic [NC*NA*DW-1:0] core_operands_i;
   logic [NC*OW-1:0]    core_op_i;
   logic [NC*FI-1:0]    core_flags_i;
   logic [DW-1:0]       core_rdata_o;
   logic [FO-1:0]       core_rflags_o;
   logic                fpu_req_o, fpu_gnt_i;
   logic [IW-1:0]       fpu_ID_o;
   logic [NA*DW-1:0]    fpu_operands_o;
   logic [OW-1:0]       fpu_op_o;
   logic [FI-1:0]       fpu_flags_o;
   logic                fpu_rvalid_i;
   logic [DW-1:0]       fpu_rdata_i;
   logic [FO-1:0]       fpu_rflags_i;
   logic [IW-1:0]       fpu_rID_i;
   logic                err_o;

   fpu_share_arbiter #(
      .NB_CORES(NC), .NB_ARGS(NA), .DATA_WIDTH(DW), .OPCODE_WIDTH(OW),
      .FLAGS_IN_WIDTH(FI), .FLAGS_OUT_WIDTH(FO), .ID_WIDTH(IW),
      .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
      .core_operands_i(core_operands_i), .core_op_i(core_op_i),
      .core_flags_i(core_flags_i), .core_rvalid_o(core_rvalid_o),
      .core_rdata_o(core_rdata_o), .core_rflags_o(core_rflags_o),
      .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i), .fpu_ID_o(fpu_ID_o),
      .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o),
      .fpu_flags_o(fpu_flags_o), .fpu_rvalid_i(fpu_rvalid_i),
      .fpu_rdata_i(fpu_rdata_i), .fpu_rflags_i(fpu_rflags_i),
      .fpu_rID_i(fpu_rID_i), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;

   int          m_ptr;
   int          m_cnt [NC];
   logic [NC-1:0] m_rv;
   logic [DW-1:0] m_rd;
   logic [FO-1:0] m_rf;
   logic        m_err;
   int          pend [$];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_ptr = 0;
      for (int k = 0; k < NC; k++) m_cnt[k] = 0;
      m_rv  = '0;
      m_rd  = '0;
      m_rf  = '0;
      m_err = 1'b0;
      pend.delete();
   endtask

   task automatic rand_payload(input int k);
      core_operands_i[k*NA*DW +: NA*DW] = {$urandom, $urandom};
      core_op_i[k*OW +: OW]             = OW'($urandom);
      core_flags_i[k*FI +: FI]          = FI'($urandom);
   endtask

   task automatic set_in(input logic [NC-1:0] req, input logic g,
                         input logic rv, input logic [IW-1:0] rid);
      int idx;
      core_req_i   = req;
      fpu_gnt_i    = g;
      fpu_rvalid_i = rv;
      fpu_rID_i    = rid;
      fpu_rdata_i  = $urandom;
      fpu_rflags_i = FO'($urandom);
      idx = int'(rid[1:0]);
      if (rv && (rid >> 2) == 0 && m_cnt[idx] != 0) begin
         for (int j = 0; j < pend.size(); j++) begin
            if (pend[j] == idx) begin
               pend.delete(j);
               break;
            end
         end
      end
   endtask

   task automatic step();
      int          win;
      int          idx;
      bit          ok;
      logic [NC-1:0] eg;
      #1;
      win = -1;
      for (int i = 0; i < NC; i++) begin
         int k;
         k = (m_ptr + i) % NC;
         if (win < 0 && core_req_i[k] && m_cnt[k] < MO) win = k;
      end
      eg = (win >= 0 && fpu_gnt_i) ? NC'(1 << win) : '0;
      chk("fpu_req", fpu_req_o, win >= 0);
      chk("core_gnt", core_gnt_o, eg);
      if (win >= 0) begin
         chk("fpu_id", fpu_ID_o, win);
         chk("fpu_ops", fpu_operands_o, core_operands_i[win*NA*DW +: NA*DW]);
         chk("fpu_opflags", {fpu_flags_o, fpu_op_o},
             {core_flags_i[win*FI +: FI], core_op_i[win*OW +: OW]});
      end
      chk("rvalid", core_rvalid_o, m_rv);
      chk("rdata", core_rdata_o, m_rd);
      chk("rflags", core_rflags_o, m_rf);
      chk("err", err_o, m_err);
      idx = int'(fpu_rID_i[1:0]);
      ok  = fpu_rvalid_i && (fpu_rID_i >> 2) == 0 && m_cnt[idx] != 0;
      @(posedge clk);
      if (eg != 0) begin
         m_cnt[win]++;
         m_ptr = (win + 1) % NC;
         pend.push_back(win);
      end
      if (ok) begin
         m_cnt[idx]--;
         m_rv = NC'(1 << idx);
         m_rd = fpu_rdata_i;
         m_rf = fpu_rflags_i;
      end else begin
         m_rv = '0;
      end
      if (fpu_rvalid_i && !ok) m_err = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NC; k++) begin
         if (eg[k] || !core_req_i[k]) rand_payload(k);
      end
   endtask

   task automatic drive(input logic [NC-1:0] req, input logic g,
                        input logic rv, input logic [IW-1:0] rid);
      set_in(req, g, rv, rid);
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_in('0, 1'b0, 1'b0, '0);
      model_reset();
      #1;
      chk("rst_gnt", core_gnt_o, 0);
      chk("rst_req", fpu_req_o, 0);
      chk("rst_rvalid", core_rvalid_o, 0);
      chk("rst_rdata", core_rdata_o, 0);
      chk("rst_rflags", core_rflags_o, 0);
      chk("rst_err", err_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic contend_step(input int exp_id);
      if (pend.size() > 0) set_in('1, 1'b1, 1'b1, IW'(pend[0]));
      else set_in('1, 1'b1, 1'b0, '0);
      #1;
      chk("rr_order", fpu_ID_o, exp_id);
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      core_req_i = '0;
      fpu_gnt_i = 1'b0;
      fpu_rvalid_i = 1'b0;
      fpu_rID_i = '0;
      fpu_rdata_i = '0;
      fpu_rflags_i = '0;
      for (int k = 0; k < NC; k++) rand_payload(k);
      model_reset();
      @(negedge clk);
      do_reset();

      set_in(4'b0100, 1'b1, 1'b0, '0);
      #1;
      chk("single_gnt", core_gnt_o, 4'b0100);
      chk("single_id", fpu_ID_o, 2);
      step();
      set_in('0, 1'b0, 1'b1, 9'd2);
      fpu_rdata_i = 32'h3F800000;
      step();
      set_in('0, 1'b0, 1'b0, '0);
      #1;
      chk("single_rv", core_rvalid_o, 4'b0100);
      chk("single_rd", core_rdata_o, 32'h3F800000);
      step();

      set_in(4'b0001, 1'b1, 1'b0, '0);
      #1 chk("lim_g1", core_gnt_o, 4'b0001);
      step();
      set_in(4'b0001, 1'b1, 1'b0, '0);
      #1 chk("lim_g2", core_gnt_o, 4'b0001);
      step();
      set_in(4'b0001, 1'b1, 1'b0, '0);
      #1 chk("lim_hold", core_gnt_o, 4'b0000);
      step();
      set_in(4'b0001, 1'b1, 1'b1, 9'd0);
      #1 chk("lim_hold_rsp", core_gnt_o, 4'b0000);
      step();
      set_in(4'b0001, 1'b1, 1'b0, '0);
      #1 chk("lim_g3", core_gnt_o, 4'b0001);
      step();
      drive('0, 1'b0, 1'b1, 9'd0);
      drive('0, 1'b0, 1'b1, 9'd0);

      drive(4'b0010, 1'b1, 1'b0, '0);
      set_in(4'b0010, 1'b1, 1'b1, 9'd1);
      #1 chk("sim_gnt", core_gnt_o, 4'b0010);
      step();
      set_in(4'b0010, 1'b1, 1'b0, '0);
      #1;
      chk("sim_rv", core_rvalid_o, 4'b0010);
      chk("sim_gnt2", core_gnt_o, 4'b0010);
      step();
      set_in(4'b0010, 1'b1, 1'b0, '0);
      #1 chk("sim_hold", core_gnt_o, 4'b0000);
      step();
      drive('0, 1'b0, 1'b1, 9'd1);
      drive('0, 1'b0, 1'b1, 9'd1);

      drive('0, 1'b0, 1'b1, 9'h005);
      set_in('0, 1'b0, 1'b0, '0);
      #1;
      chk("bad_rv", core_rvalid_o, 0);
      chk("bad_err", err_o, 1);
      step();
      drive('0, 1'b0, 1'b1, 9'd3);
      repeat (3) drive('0, 1'b0, 1'b0, '0);
      #1 chk("err_sticky", err_o, 1);

      do_reset();
      for (int i = 0; i < 9; i++) contend_step(i % NC);
      set_in('1, 1'b1, 1'b0, '0);
      do_reset();
      for (int i = 0; i < 5; i++) contend_step(i % NC);
      while (pend.size() > 0) drive('0, 1'b0, 1'b1, IW'(pend[0]));
      drive('0, 1'b0, 1'b0, '0);

      for (int n = 0; n < 400; n++) begin
         logic [IW-1:0] rid;
         logic          rv;
         rv  = 1'b0;
         rid = '0;
         if ($urandom_range(49) == 0) begin
            rv  = 1'b1;
            rid = {7'($urandom_range(127, 1)), 2'($urandom)};
         end else if (pend.size() > 0 && $urandom_range(1) == 1) begin
            rv  = 1'b1;
            rid = IW'(pend[$urandom_range(pend.size() - 1)]);
         end
         drive(NC'($urandom), $urandom_range(3) != 0, rv, rid);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
